// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Handles load-use, taken branch, multi-cycle MD and memory wait.
module pipeline_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Id_rs,
    input  logic [4:0]       Id_rt,
    input  logic             Id_use_rs,
    input  logic             Id_use_rt,
    input  logic [4:0]       Ex_rt,
    input  logic             Ex_mem_read,
    input  logic             Ex_branch_taken,
    input  logic             Ex_md,
    input  logic             Mem_wait,
    output logic             Pc_en,
    output logic             Ifid_en,
    output logic             Idex_en,
    output logic             Exmem_en,
    output logic             Memwb_en,
    output logic             Ifid_flush,
    output logic             Idex_flush,
    output logic             Exmem_flush,
    output logic             Md_busy,
    output logic [CNT_W-1:0] Stall_cnt
);

    localparam int MW = $clog2(MD_LAT + 1);

    typedef enum logic [1:0] {RUN, MDU, MDDONE} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] md_cnt, md_cnt_nxt;
    logic          lu, mdt, md_stall;

    assign lu = Ex_mem_read && (Ex_rt != 5'd0) &&
                ((Id_use_rs && (Id_rs == Ex_rt)) ||
                 (Id_use_rt && (Id_rt == Ex_rt)));
    assign mdt      = (state == RUN) && Ex_md;
    assign md_stall = mdt || (state == MDU);

    always_comb begin
        Pc_en       = 1'b1;
        Ifid_en     = 1'b1;
        Idex_en     = 1'b1;
        Exmem_en    = 1'b1;
        Memwb_en    = 1'b1;
        Ifid_flush  = 1'b0;
        Idex_flush  = 1'b0;
        Exmem_flush = 1'b0;
        Md_busy     = 1'b0;
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        if (Rst) begin
            Ifid_flush  = 1'b1;
            Idex_flush  = 1'b1;
            Exmem_flush = 1'b1;
        end else begin
            // Busy stays visible through a memory wait so the MD window is observable.
            Md_busy = md_stall;
            if (Mem_wait) begin
                Pc_en    = 1'b0;
                Ifid_en  = 1'b0;
                Idex_en  = 1'b0;
                Exmem_en = 1'b0;
                Memwb_en = 1'b0;
            end else if (md_stall) begin
                Pc_en       = 1'b0;
                Ifid_en     = 1'b0;
                Idex_en     = 1'b0;
                Exmem_flush = 1'b1;
            end else if (Ex_branch_taken) begin
                Ifid_flush = 1'b1;
                Idex_flush = 1'b1;
            end else if (lu) begin
                Pc_en      = 1'b0;
                Ifid_en    = 1'b0;
                Idex_flush = 1'b1;
            end

            if (!Mem_wait) begin
                unique case (state)
                    RUN: begin
                        if (Ex_md) begin
                            state_nxt  = MDU;
                            md_cnt_nxt = MW'(MD_LAT - 1);
                        end
                    end
                    MDU: begin
                        md_cnt_nxt = md_cnt - MW'(1);
                        if (md_cnt == MW'(1))
                            state_nxt = MDDONE;
                    end
                    MDDONE:  state_nxt = RUN;
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= RUN;
            md_cnt    <= '0;
            Stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!Pc_en && (Stall_cnt != {CNT_W{1'b1}}))
                Stall_cnt <= Stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MD_LAT=4, CNT_W=3).
// Reference model counts served MD cycles instead of tracking FSM states.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Rst;
    logic [4:0] Id_rs, Id_rt, Ex_rt;
    logic Id_use_rs, Id_use_rt, Ex_mem_read;
    logic Ex_branch_taken, Ex_md, Mem_wait;
    logic Pc_en, Ifid_en, Idex_en, Exmem_en, Memwb_en;
    logic Ifid_flush, Idex_flush, Exmem_flush, Md_busy;
    logic [CNT_W-1:0] Stall_cnt;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .Id_rs(Id_rs), .Id_rt(Id_rt),
        .Id_use_rs(Id_use_rs), .Id_use_rt(Id_use_rt),
        .Ex_rt(Ex_rt), .Ex_mem_read(Ex_mem_read),
        .Ex_branch_taken(Ex_branch_taken), .Ex_md(Ex_md),
        .Mem_wait(Mem_wait),
        .Pc_en(Pc_en), .Ifid_en(Ifid_en), .Idex_en(Idex_en),
        .Exmem_en(Exmem_en), .Memwb_en(Memwb_en),
        .Ifid_flush(Ifid_flush), .Idex_flush(Idex_flush),
        .Exmem_flush(Exmem_flush), .Md_busy(Md_busy),
        .Stall_cnt(Stall_cnt)
    );

    typedef struct {
        logic [4:0] en;
        logic [2:0] fl;
        logic       busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;

    // model state: MD cycles served so far, "just finished" flag, stall count
    int m_served = 0;
    bit m_done   = 0;
    int m_cnt    = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("en", int'({Pc_en, Ifid_en, Idex_en, Exmem_en, Memwb_en}), int'(e.en));
            chk("flush", int'({Ifid_flush, Idex_flush, Exmem_flush}), int'(e.fl));
            chk("md_busy", int'(Md_busy), int'(e.busy));
            chk("stall_cnt", int'(Stall_cnt), int'(e.cnt));
        end
    end

    task automatic clr();
        Rst = 0; Id_rs = 0; Id_rt = 0; Ex_rt = 0;
        Id_use_rs = 0; Id_use_rt = 0; Ex_mem_read = 0;
        Ex_branch_taken = 0; Ex_md = 0; Mem_wait = 0;
    endtask

    // inputs are already applied; predict this cycle, then advance one clock
    task automatic step();
        exp_t e;
        bit lu, md_on;
        lu = Ex_mem_read && (Ex_rt != 0) &&
             ((Id_use_rs && Id_rs == Ex_rt) || (Id_use_rt && Id_rt == Ex_rt));
        md_on = (m_served > 0) || (!m_done && Ex_md);
        e.cnt = CNT_W'(m_cnt);
        if (Rst) begin
            e.en = 5'b11111; e.fl = 3'b111; e.busy = 0;
            m_served = 0; m_done = 0; m_cnt = 0;
        end else begin
            e.en = 5'b11111; e.fl = 3'b000; e.busy = md_on;
            if (Mem_wait) e.en = 5'b00000;
            else if (md_on) begin e.en = 5'b00011; e.fl = 3'b001; end
            else if (Ex_branch_taken) e.fl = 3'b110;
            else if (lu) begin e.en = 5'b00111; e.fl = 3'b010; end
            if (!e.en[4] && m_cnt < CMAX) m_cnt++;
            if (!Mem_wait) begin
                if (md_on) begin
                    m_served++;
                    if (m_served == MD_LAT) begin m_served = 0; m_done = 1; end
                end else begin
                    m_done = 0;
                end
            end
        end
        q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        clr(); Rst = 1;
        repeat (n) step();
        Rst = 0;
    endtask

    initial begin
        clr(); Rst = 1;
        @(posedge Clk); #1;
        do_reset(2);
        clr(); step();

        // load-use, then same with Ex_rt = 0
        Ex_mem_read = 1; Ex_rt = 5; Id_rs = 5; Id_use_rs = 1; step();
        clr(); step();
        Ex_mem_read = 1; Ex_rt = 0; Id_rs = 0; Id_use_rs = 1; step();
        // branch beats load-use
        Ex_mem_read = 1; Ex_rt = 7; Id_rt = 7; Id_use_rt = 1;
        Ex_branch_taken = 1; step();
        clr(); step();

        // MD held through stall and MDDONE
        do_reset(1);
        Ex_md = 1; repeat (5) step();
        clr(); repeat (2) step();

        // MD with two wait cycles in the second MDU cycle
        do_reset(1);
        Ex_md = 1; repeat (2) step();
        Mem_wait = 1; repeat (2) step();
        Mem_wait = 0; repeat (3) step();
        clr(); repeat (2) step();

        // counter saturation
        do_reset(1);
        Ex_mem_read = 1; Ex_rt = 3; Id_rs = 3; Id_use_rs = 1;
        repeat (9) step();
        clr(); repeat (2) step();

        // randomized traffic, illegal MD+branch combos included
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            Rst             = ($urandom_range(0, 99) < 2);
            Id_rs           = 5'($urandom_range(0, 3));
            Id_rt           = 5'($urandom_range(0, 3));
            Ex_rt           = 5'($urandom_range(0, 3));
            Id_use_rs       = 1'($urandom_range(0, 1));
            Id_use_rt       = 1'($urandom_range(0, 1));
            Ex_mem_read     = ($urandom_range(0, 99) < 40);
            Ex_branch_taken = ($urandom_range(0, 99) < 20);
            Ex_md           = ($urandom_range(0, 99) < 15);
            Mem_wait        = ($urandom_range(0, 99) < 15);
            step();
        end
        clr();

        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge Clk); budget--;
            end
            if (q.size() > 0) begin
                fails++;
                $display("FAIL drain: %0d entries left, expected 0", q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
